// File: rtl/stream_sync_scheduler.sv
// Orbit-aligned restart/enable scheduler for BRAM pattern-streaming links.
// Optional orbit watchdog enabled by defining STREAM_SYNC_TIMEOUT_EN.
module stream_sync_scheduler #(
  parameter int N_LINKS   = 4,
  parameter int REPEAT_W  = 10,
  parameter int DELAY_W   = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_arm,
  input  logic                cfg_stop,
  input  logic [DELAY_W-1:0]  cfg_start_delay,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic [N_LINKS-1:0]  cfg_link_mask,
  input  logic                fc_orbitSync,
  output logic [N_LINKS-1:0]  link_force_sync,
  output logic [N_LINKS-1:0]  link_enable,
  output logic                busy,
  output logic [1:0]          state,
  output logic [REPEAT_W-1:0] orbit_count,
  output logic [15:0]         pattern_count,
  output logic                sync_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  if (TIMEOUT_W < 1) begin : g_bad_timeout
    $error("TIMEOUT_W must be at least 1");
  end

  state_t              state_q, state_n;
  logic [N_LINKS-1:0]  mask_q, mask_n;
  logic [DELAY_W-1:0]  delay_q, delay_n;
  logic [REPEAT_W-1:0] rpt_q, rpt_n;
  logic [REPEAT_W-1:0] orbit_q, orbit_n;
  logic [15:0]         pat_q, pat_n;
  logic [N_LINKS-1:0]  force_q, force_n;
  logic [N_LINKS-1:0]  en_q, en_n;

`ifdef STREAM_SYNC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_n;
  logic                 err_q, err_n;
`endif

  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    delay_n = delay_q;
    rpt_n   = rpt_q;
    orbit_n = orbit_q;
    pat_n   = pat_q;
    force_n = '0;
    en_n    = en_q;
`ifdef STREAM_SYNC_TIMEOUT_EN
    err_n   = err_q;
`endif
    if (cfg_stop) begin
      state_n = S_IDLE;
      en_n    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_arm) begin
            state_n = S_ARMED;
            mask_n  = cfg_link_mask;
            delay_n = cfg_start_delay;
            rpt_n   = cfg_repeat;
            pat_n   = '0;
`ifdef STREAM_SYNC_TIMEOUT_EN
            err_n   = 1'b0;
`endif
          end
        end
        S_ARMED: begin
          if (fc_orbitSync) begin
            if (delay_q == '0) begin
              state_n = S_RUN;
              force_n = mask_q & ~force_q;
              en_n    = mask_q;
              orbit_n = '0;
            end else begin
              delay_n = delay_q - DELAY_W'(1);
            end
          end
        end
        S_RUN: begin
          if (fc_orbitSync) begin
            // repeat==0 means single shot: count freely, never restart
            if (rpt_q != '0 &&
                orbit_q == rpt_q - REPEAT_W'(1)) begin
              force_n = mask_q & ~force_q;
              orbit_n = '0;
              if (pat_q != 16'hFFFF)
                pat_n = pat_q + 16'd1;
            end else begin
              orbit_n = orbit_q + REPEAT_W'(1);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
`ifdef STREAM_SYNC_TIMEOUT_EN
      if (state_q != S_IDLE && wd_q == '1
          && !fc_orbitSync) begin
        state_n = S_IDLE;
        en_n    = '0;
        force_n = '0;
        err_n   = 1'b1;
      end
`endif
    end
  end

`ifdef STREAM_SYNC_TIMEOUT_EN
  // orbit silence watchdog, restarted on every orbit and state change
  always_comb begin
    if (state_n == S_IDLE || state_n != state_q
        || fc_orbitSync)
      wd_n = '0;
    else
      wd_n = wd_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_n;
      err_q <= err_n;
    end
  end

  assign sync_error = err_q;
`else
  assign sync_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      delay_q <= '0;
      rpt_q   <= '0;
      orbit_q <= '0;
      pat_q   <= '0;
      force_q <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_n;
      mask_q  <= mask_n;
      delay_q <= delay_n;
      rpt_q   <= rpt_n;
      orbit_q <= orbit_n;
      pat_q   <= pat_n;
      force_q <= force_n;
      en_q    <= en_n;
    end
  end

  assign link_force_sync = force_q;
  assign link_enable     = en_q;
  assign state           = state_q;
  assign busy            = (state_q != S_IDLE);
  assign orbit_count     = orbit_q;
  assign pattern_count   = pat_q;

endmodule

// File: tb/tb_stream_sync_scheduler.sv
// Directed bench for stream_sync_scheduler.
// Outputs are sampled 1 time unit after the rising edge.
module tb_stream_sync_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_arm = 1'b0;
  logic       cfg_stop = 1'b0;
  logic [7:0] cfg_start_delay = '0;
  logic [9:0] cfg_repeat = '0;
  logic [3:0] cfg_link_mask = '0;
  logic       fc_orbitSync = 1'b0;
  logic [3:0] link_force_sync;
  logic [3:0] link_enable;
  logic       busy;
  logic [1:0] state;
  logic [9:0] orbit_count;
  logic [15:0] pattern_count;
  logic       sync_error;

  int checks = 0;
  int failures = 0;

  stream_sync_scheduler #(
    .N_LINKS(4), .REPEAT_W(10),
    .DELAY_W(8), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop),
    .cfg_start_delay(cfg_start_delay),
    .cfg_repeat(cfg_repeat),
    .cfg_link_mask(cfg_link_mask),
    .fc_orbitSync(fc_orbitSync),
    .link_force_sync(link_force_sync),
    .link_enable(link_enable),
    .busy(busy), .state(state),
    .orbit_count(orbit_count),
    .pattern_count(pattern_count),
    .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arm(input logic [3:0] m,
                     input logic [7:0] d,
                     input logic [9:0] r);
    cfg_link_mask   = m;
    cfg_start_delay = d;
    cfg_repeat      = r;
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic orbit(input int gap);
    tick(gap - 1);
    fc_orbitSync = 1'b1;
    tick();
    fc_orbitSync = 1'b0;
  endtask

  task automatic stop_pulse();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    checks++;
    if ({state, busy, link_enable, link_force_sync} !== 11'd0) begin
      failures++;
      $display("FAIL reset_ctrl got st=%0d busy=%b en=%b fs=%b exp 0",
               state, busy, link_enable, link_force_sync);
    end
    checks++;
    if ({orbit_count, pattern_count, sync_error} !== 27'd0) begin
      failures++;
      $display("FAIL reset_cnt got oc=%0d pc=%0d err=%b exp 0",
               orbit_count, pattern_count, sync_error);
    end
  endtask

  task automatic test_basic_start();
    arm(4'b0101, 8'd2, 10'd3);
    checks++;
    if (state !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_armed got st=%0d busy=%b exp 1/1", state, busy);
    end
    orbit(100);
    orbit(100);
    checks++;
    if (state !== 2'd1 || link_force_sync !== 4'b0000) begin
      failures++;
      $display("FAIL basic_delay got st=%0d fs=%b exp 1/0000",
               state, link_force_sync);
    end
    orbit(100);
    checks++;
    if (state !== 2'd2 || link_force_sync !== 4'b0101
        || link_enable !== 4'b0101 || orbit_count !== 10'd0) begin
      failures++;
      $display("FAIL basic_start got st=%0d fs=%b en=%b oc=%0d exp 2/0101/0101/0",
               state, link_force_sync, link_enable, orbit_count);
    end
    tick();
    checks++;
    if (link_force_sync !== 4'b0000 || link_enable !== 4'b0101) begin
      failures++;
      $display("FAIL basic_width got fs=%b en=%b exp 0000/0101",
               link_force_sync, link_enable);
    end
    orbit(100);
    orbit(100);
    checks++;
    if (orbit_count !== 10'd2 || link_force_sync !== 4'b0000) begin
      failures++;
      $display("FAIL basic_count got oc=%0d fs=%b exp 2/0000",
               orbit_count, link_force_sync);
    end
    orbit(100);
    checks++;
    if (link_force_sync !== 4'b0101 || orbit_count !== 10'd0
        || pattern_count !== 16'd1) begin
      failures++;
      $display("FAIL basic_restart got fs=%b oc=%0d pc=%0d exp 0101/0/1",
               link_force_sync, orbit_count, pattern_count);
    end
  endtask

  task automatic test_stop_rearm();
    stop_pulse();
    checks++;
    if (state !== 2'd0 || link_enable !== 4'b0000
        || link_force_sync !== 4'b0000 || pattern_count !== 16'd1) begin
      failures++;
      $display("FAIL stop_run got st=%0d en=%b fs=%b pc=%0d exp 0/0000/0000/1",
               state, link_enable, link_force_sync, pattern_count);
    end
    arm(4'b1111, 8'd0, 10'd2);
    checks++;
    if (pattern_count !== 16'd0 || state !== 2'd1) begin
      failures++;
      $display("FAIL rearm_clear got pc=%0d st=%0d exp 0/1",
               pattern_count, state);
    end
    orbit(10);
    checks++;
    if (link_force_sync !== 4'b1111 || link_enable !== 4'b1111) begin
      failures++;
      $display("FAIL rearm_mask got fs=%b en=%b exp 1111/1111",
               link_force_sync, link_enable);
    end
    stop_pulse();
  endtask

  task automatic test_single_shot();
    int pulses = 0;
    arm(4'b0011, 8'd0, 10'd0);
    for (int i = 0; i < 5; i++) begin
      orbit(10);
      if (link_force_sync !== 4'b0000) pulses++;
      if (i == 0) begin
        checks++;
        if (link_force_sync !== 4'b0011) begin
          failures++;
          $display("FAIL single_first got fs=%b exp 0011", link_force_sync);
        end
      end
    end
    checks++;
    if (pulses != 1 || orbit_count !== 10'd4 || pattern_count !== 16'd0) begin
      failures++;
      $display("FAIL single_shot got pulses=%0d oc=%0d pc=%0d exp 1/4/0",
               pulses, orbit_count, pattern_count);
    end
    stop_pulse();
  endtask

  task automatic test_stop_priority();
    cfg_link_mask = 4'b0001;
    cfg_start_delay = 8'd0;
    cfg_repeat = 10'd3;
    cfg_arm = 1'b1;
    cfg_stop = 1'b1;
    tick();
    cfg_arm = 1'b0;
    cfg_stop = 1'b0;
    checks++;
    if (state !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_wins got st=%0d busy=%b exp 0/0", state, busy);
    end
    fc_orbitSync = 1'b1;
    arm(4'b0001, 8'd0, 10'd3);
    fc_orbitSync = 1'b0;
    tick();
    checks++;
    if (state !== 2'd1 || link_force_sync !== 4'b0000) begin
      failures++;
      $display("FAIL arm_orbit got st=%0d fs=%b exp 1/0000",
               state, link_force_sync);
    end
    orbit(10);
    checks++;
    if (state !== 2'd2 || link_force_sync !== 4'b0001) begin
      failures++;
      $display("FAIL arm_orbit_start got st=%0d fs=%b exp 2/0001",
               state, link_force_sync);
    end
    arm(4'b1111, 8'd5, 10'd0);
    orbit(10);
    orbit(10);
    checks++;
    if (state !== 2'd2 || orbit_count !== 10'd2 || link_enable !== 4'b0001) begin
      failures++;
      $display("FAIL arm_ignored got st=%0d oc=%0d en=%b exp 2/2/0001",
               state, orbit_count, link_enable);
    end
    orbit(10);
    checks++;
    if (link_force_sync !== 4'b0001 || pattern_count !== 16'd1) begin
      failures++;
      $display("FAIL arm_ignored_restart got fs=%b pc=%0d exp 0001/1",
               link_force_sync, pattern_count);
    end
    stop_pulse();
  endtask

  task automatic test_back_to_back();
    arm(4'b0000, 8'd0, 10'd1);
    orbit(3);
    checks++;
    if (state !== 2'd2 || link_force_sync !== 4'b0000
        || link_enable !== 4'b0000) begin
      failures++;
      $display("FAIL mask_zero got st=%0d fs=%b en=%b exp 2/0000/0000",
               state, link_force_sync, link_enable);
    end
    orbit(3);
    orbit(3);
    orbit(3);
    checks++;
    if (pattern_count !== 16'd3 || orbit_count !== 10'd0) begin
      failures++;
      $display("FAIL repeat_one got pc=%0d oc=%0d exp 3/0",
               pattern_count, orbit_count);
    end
    stop_pulse();
  endtask

  task automatic test_reset_midrun();
    arm(4'b1010, 8'd0, 10'd2);
    orbit(10);
    orbit(10);
    checks++;
    if (state !== 2'd2 || orbit_count !== 10'd1) begin
      failures++;
      $display("FAIL midrun_setup got st=%0d oc=%0d exp 2/1",
               state, orbit_count);
    end
    tick(9);
    reset = 1'b1;
    fc_orbitSync = 1'b1;
    tick();
    reset = 1'b0;
    fc_orbitSync = 1'b0;
    checks++;
    if (link_force_sync !== 4'b0000 || link_enable !== 4'b0000
        || state !== 2'd0 || busy !== 1'b0
        || orbit_count !== 10'd0 || pattern_count !== 16'd0) begin
      failures++;
      $display("FAIL midrun_reset got fs=%b en=%b st=%0d oc=%0d pc=%0d exp all 0",
               link_force_sync, link_enable, state, orbit_count, pattern_count);
    end
    tick();
    checks++;
    if (link_force_sync !== 4'b0000 || state !== 2'd0) begin
      failures++;
      $display("FAIL midrun_trail got fs=%b st=%0d exp 0000/0",
               link_force_sync, state);
    end
  endtask

  task automatic test_watchdog();
    arm(4'b0001, 8'd0, 10'd0);
    tick(250);
`ifdef STREAM_SYNC_TIMEOUT_EN
    checks++;
    if (state !== 2'd1 || sync_error !== 1'b0) begin
      failures++;
      $display("FAIL wd_early got st=%0d err=%b exp 1/0", state, sync_error);
    end
    tick(10);
    checks++;
    if (state !== 2'd0 || sync_error !== 1'b1 || link_enable !== 4'b0000) begin
      failures++;
      $display("FAIL wd_fire got st=%0d err=%b en=%b exp 0/1/0000",
               state, sync_error, link_enable);
    end
    arm(4'b0001, 8'd0, 10'd0);
    checks++;
    if (sync_error !== 1'b0 || state !== 2'd1) begin
      failures++;
      $display("FAIL wd_clear got err=%b st=%0d exp 0/1", sync_error, state);
    end
`else
    tick(10);
    checks++;
    if (state !== 2'd1 || sync_error !== 1'b0) begin
      failures++;
      $display("FAIL no_wd got st=%0d err=%b exp 1/0", state, sync_error);
    end
`endif
    stop_pulse();
  endtask

  initial begin
    test_reset();
    test_basic_start();
    test_stop_rearm();
    test_single_shot();
    test_stop_priority();
    test_back_to_back();
    test_reset_midrun();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
